// File: rtl/touch_chord.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | touch_chord: N-pad touch decoder (sync + debounce) emitting one chord event |
// | per gesture. Optional long-press flag: define TOUCH_CHORD_LONG_EN.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module touch_chord #(
  parameter int N_PADS       = 2,
  parameter int DEBOUNCE_CYC = 480_000,
  parameter int LONG_CYC     = 48_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_PADS-1:0] i_pad,
  output logic [N_PADS-1:0] o_state,
  output logic              o_busy,
  output logic              o_valid,
  output logic [N_PADS-1:0] o_code,
  output logic              o_long
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  generate
    if (N_PADS < 1 || N_PADS > 8 || DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_param_check
      $error("touch_chord: parameter out of range");
    end
  endgenerate

  logic [N_PADS-1:0] sync1_q, sync2_q;
  logic [N_PADS-1:0] state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [N_PADS];
  logic [CNT_W-1:0]  cnt_d [N_PADS];
  logic [N_PADS-1:0] w_pressed;

  assign w_pressed = ~sync2_q;

  // Integrating debounce: any sample equal to the accepted level restarts the count.
  always_comb begin
    state_d = state_q;
    for (int k = 0; k < N_PADS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (w_pressed[k] == state_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        state_d[k] = w_pressed[k];
        cnt_d[k]   = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      state_q <= '0;
      for (int k = 0; k < N_PADS; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q <= i_pad;
      sync2_q <= sync1_q;
      state_q <= state_d;
      for (int k = 0; k < N_PADS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  typedef enum logic [0:0] {IDLE = 1'b0, GESTURE = 1'b1} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [N_PADS-1:0] acc_q, acc_d;
  logic [N_PADS-1:0] code_q, code_d;
  logic              valid_q, valid_d;

`ifdef TOUCH_CHORD_LONG_EN
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    acc_d   = acc_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef TOUCH_CHORD_LONG_EN
    hold_d  = hold_q;
    long_d  = long_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (|state_q) begin
          fsm_d = GESTURE;
          acc_d = state_q;
`ifdef TOUCH_CHORD_LONG_EN
          hold_d = HOLD_ONE;
`endif
        end
      end
      GESTURE: begin
        if (|state_q) begin
          acc_d = acc_q | state_q;
`ifdef TOUCH_CHORD_LONG_EN
          if (hold_q < HOLD_MAX) hold_d = hold_q + HOLD_ONE;
`endif
        end else begin
          // acc always holds the first-press bits, so the emitted code is nonzero.
          valid_d = 1'b1;
          code_d  = acc_q;
          fsm_d   = IDLE;
`ifdef TOUCH_CHORD_LONG_EN
          long_d  = (hold_q >= HOLD_MAX);
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsm_q   <= IDLE;
      acc_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
`ifdef TOUCH_CHORD_LONG_EN
      hold_q  <= '0;
      long_q  <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef TOUCH_CHORD_LONG_EN
      hold_q  <= hold_d;
      long_q  <= long_d;
`endif
    end
  end

  assign o_state = state_q;
  assign o_busy  = (fsm_q == GESTURE);
  assign o_valid = valid_q;
  assign o_code  = code_q;
`ifdef TOUCH_CHORD_LONG_EN
  assign o_long  = long_q;
`else
  assign o_long  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_touch_chord.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_touch_chord: directed bench for touch_chord (N_PADS=2, DEBOUNCE=4, LONG=20)|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_touch_chord;

`ifdef TOUCH_CHORD_LONG_EN
  localparam logic LONG_EN = 1'b1;
`else
  localparam logic LONG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] pad;
  logic [1:0] o_state;
  logic       o_busy;
  logic       o_valid;
  logic [1:0] o_code;
  logic       o_long;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         valid_cnt = 0;
  int         zero_code = 0;
  int         v0;
  logic [1:0] or_state = '0;

  touch_chord #(
    .N_PADS      (2),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pad  (pad),
    .o_state(o_state),
    .o_busy (o_busy),
    .o_valid(o_valid),
    .o_code (o_code),
    .o_long (o_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    or_state = or_state | o_state;
    if (!rst && o_valid) begin
      valid_cnt++;
      if (o_code == 2'b00) zero_code++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    pad = 2'b11;
    tick(3);
    check("rst_state", 32'(o_state), 0);
    check("rst_busy",  32'(o_busy),  0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_code",  32'(o_code),  0);
    check("rst_long",  32'(o_long),  0);
    rst = 1'b0;
    tick(2);

    // 3-cycle glitch on pad0 must be rejected
    or_state = '0;
    v0 = valid_cnt;
    pad = 2'b10;
    tick(3);
    pad = 2'b11;
    tick(12);
    check("glitch_state", 32'(or_state), 0);
    check("glitch_valid", 32'(valid_cnt - v0), 0);

    // single 10-cycle press of pad0
    v0 = valid_cnt;
    pad = 2'b10;
    tick(5);
    check("press_state_early", 32'(o_state), 0);
    tick(1);
    check("press_state_edge6", 32'(o_state), 1);
    check("press_busy_edge6",  32'(o_busy),  0);
    tick(1);
    check("press_busy_edge7",  32'(o_busy),  1);
    tick(3);
    pad = 2'b11;
    tick(6);
    check("rel_state",      32'(o_state), 0);
    check("rel_valid_pre",  32'(o_valid), 0);
    tick(1);
    check("rel_valid",      32'(o_valid), 1);
    check("rel_code",       32'(o_code),  1);
    check("rel_long",       32'(o_long),  0);
    tick(1);
    check("rel_valid_post", 32'(o_valid), 0);
    check("rel_busy_post",  32'(o_busy),  0);
    tick(10);
    check("single_code_hold", 32'(o_code), 1);
    check("single_events",    32'(valid_cnt - v0), 1);

    // two-pad chord with overlapping presses
    v0 = valid_cnt;
    pad = 2'b10;
    tick(2);
    pad = 2'b00;
    tick(8);
    pad = 2'b01;
    tick(5);
    pad = 2'b11;
    tick(20);
    check("chord_events", 32'(valid_cnt - v0), 1);
    check("chord_code",   32'(o_code), 3);
    check("chord_long",   32'(o_long), 0);

    // 40-cycle press of pad1: long when the feature is built
    v0 = valid_cnt;
    pad = 2'b01;
    tick(40);
    pad = 2'b11;
    tick(20);
    check("long_events", 32'(valid_cnt - v0), 1);
    check("long_code",   32'(o_code), 2);
    check("long_flag",   32'(o_long), 32'(LONG_EN));

    // reset in mid-gesture aborts it; held pad is re-accepted afterwards
    v0 = valid_cnt;
    pad = 2'b10;
    tick(8);
    check("abort_busy_pre", 32'(o_busy), 1);
    rst = 1'b1;
    #1;
    check("abort_state", 32'(o_state), 0);
    check("abort_busy",  32'(o_busy),  0);
    check("abort_valid", 32'(o_valid), 0);
    check("abort_code",  32'(o_code),  0);
    check("abort_long",  32'(o_long),  0);
    tick(5);
    rst = 1'b0;
    tick(6);
    check("reacq_state", 32'(o_state), 1);
    tick(1);
    check("reacq_busy",   32'(o_busy), 1);
    check("abort_events", 32'(valid_cnt - v0), 0);
    tick(2);
    pad = 2'b11;
    tick(20);
    check("reacq_events", 32'(valid_cnt - v0), 1);
    check("reacq_code",   32'(o_code), 1);
    check("reacq_long",   32'(o_long), 0);
    check("never_zero_code", 32'(zero_code), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/touch_chord.md
# touch_chord

Parametrised touch-pad gesture decoder for Fomu user pads: N active-low pads, each with a 2-FF synchroniser and an integrating debouncer. A gesture FSM ORs every pad pressed from first touch until all pads are released. It then emits one event carrying the chord code and a long-press flag. It sits between the SB_IO pad inputs (pull-ups enabled) and application logic such as LED drivers or command decoders. It generalises the fixed two-pad, three-button decode to N pads, clean debounced levels, and release-time chord/long-press events.

## Interface
- N_PADS, 2, number of touch pads (1..8)
- DEBOUNCE_CYC, 480_000, consecutive stable cycles required to accept a level change (≥1; 10 ms at 48 MHz)
- LONG_CYC, 48_000_000, gesture duration in cycles at or above which the event is flagged long (≥1)
- i_clk  input  1  system clock (48 MHz global buffer)
- i_rst  input  1  reset, asynchronous, active-high
- i_pad  input  N_PADS  raw pad levels; 0 = touched/pressed
- o_state  output  N_PADS  debounced pressed level per pad; 1 = pressed
- o_busy  output  1  gesture in progress
- o_valid  output  1  one-cycle event strobe
- o_code  output  N_PADS  OR of all pads pressed during the last gesture; held until the next event
- o_long  output  1  last gesture lasted ≥ LONG_CYC cycles; held with o_code

## Operation
- Reset values: all sync flops 1 (released), debounce counters 0, o_state 0, o_busy 0, o_valid 0, o_code 0, o_long 0, FSM IDLE, hold counter 0.
- Per pad: p = ~sync2. If p == o_state[k], cnt_k <= 0. Otherwise cnt_k increments. When it would reach DEBOUNCE_CYC, o_state[k] <= p and cnt_k <= 0. Counter width is $clog2(DEBOUNCE_CYC+1). Pads are fully independent.
- FSM states: IDLE, GESTURE.
- IDLE: when |o_state, go to GESTURE with acc <= o_state and hold <= 1. o_busy is 1 while in GESTURE.
- GESTURE while |o_state: acc <= acc | o_state; hold increments, saturating at LONG_CYC.
- GESTURE with o_state == 0: o_valid <= 1 for exactly one cycle, o_code <= acc, o_long <= (hold ≥ LONG_CYC), then go to IDLE.
- Releasing and re-pressing one pad while another stays pressed stays in the same gesture; no event is emitted.
- A press seen in the cycle the event is emitted is picked up from IDLE on the next cycle. No press is lost.
- Reset asserted mid-gesture aborts it: no event, o_code/o_long cleared. Reset mid-debounce discards the partial count.
- o_code is never 0 when o_valid is 1.

## Timing
- The raw pad change reaches p after 2 clock edges.
- o_state updates DEBOUNCE_CYC + 2 edges after the first edge that sampled a stable new level.
- o_busy rises 1 cycle after o_state becomes nonzero.
- o_valid rises 1 cycle after o_state returns to all-zero; it lasts 1 cycle. o_code/o_long are valid in the same cycle and hold afterwards.
- A glitch shorter than DEBOUNCE_CYC cycles (after sync) produces no o_state change.
- All outputs are registered; no combinational path from i_pad to any output.

## Configuration
- TOUCH_CHORD_LONG_EN defined: the hold counter and o_long logic are built as above.
- TOUCH_CHORD_LONG_EN undefined: no hold counter; o_long is a constant 0; LONG_CYC is ignored. All other behaviour is identical.

## Test plan
Bench parameters: N_PADS=2, DEBOUNCE_CYC=4, LONG_CYC=20, TOUCH_CHORD_LONG_EN defined unless noted.
- Reset with pads held at 1 -> o_state=00, o_busy=0, o_valid=0, o_code=00, o_long=0; a 5-cycle i_rst pulse mid-run restores these immediately.
- i_pad[0]=0 for 3 cycles, then 1 -> o_state stays 00; no o_valid.
- i_pad[0]=0 for 10 cycles, then 1 -> o_state[0] rises 6 edges after the first low sample. One o_valid with o_code=01, o_long=0; o_code holds 01 afterwards.
- Chord: pad0 low, pad1 low 2 cycles later, pad0 high after 8 more, pad1 high after 5 more -> exactly one o_valid, o_code=11, o_long=0.
- pad1 low for 40 cycles -> o_code=10, o_long=1. With the macro undefined, the same stimulus gives o_code=10, o_long=0.
- pad0 pressed, i_rst pulsed while o_busy=1, pad0 held then released -> no o_valid for the aborted gesture. After reset, the debouncer re-accepts the held level, a new gesture starts, and the release yields o_code=01.
